// File: rtl/posit_accum_feeder.sv
// Posit accumulator feeder: streams a batch of posit terms into the accumulator, then presents the sum.
// Optional DRAIN watchdog enabled by defining POSIT_FEEDER_TIMEOUT_EN.
module posit_accum_feeder #(
  parameter int N       = 32,
  parameter int ES      = 3,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N-1:0]     s_data,
  input  logic             s_last,
  output logic             acc_clr,
  output logic             acc_start,
  output logic [N-1:0]     acc_in1,
  input  logic [N-1:0]     acc_result,
  input  logic             acc_inf,
  input  logic             acc_zero,
  input  logic             acc_done,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N-1:0]     m_result,
  output logic             m_inf,
  output logic             m_zero,
  output logic [CNT_W-1:0] m_count,
  output logic             m_timeout
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, HOLD} state_t;

  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  state_t           r_state, w_next;
  logic             r_acc_start;
  logic [N-1:0]     r_acc_in1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_nar;
  logic [N-1:0]     r_m_result;
  logic             r_m_inf, r_m_zero;
  logic             w_hs, w_tmo, w_accept;
  logic             w_unused_cfg;

  // ES only describes the number format; the feeder never decodes it.
  assign w_unused_cfg = |{ES, TIMEOUT};

  assign w_hs     = s_valid & s_ready;
  assign w_accept = m_valid & m_ready;

`ifdef POSIT_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_m_tmo;

  always_ff @(posedge clk) begin
    if (rst || r_state != DRAIN) r_tmo_cnt <= '0;
    else                         r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Fires on the TIMEOUT-th DRAIN cycle; a real acc_done in that cycle still wins.
  assign w_tmo = (r_state == DRAIN) && !acc_done && (r_tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)                             r_m_tmo <= 1'b0;
    else if (r_state == DRAIN && acc_done) r_m_tmo <= 1'b0;
    else if (w_tmo)                      r_m_tmo <= 1'b1;
    else if (w_accept)                   r_m_tmo <= 1'b0;
  end
  assign m_timeout = r_m_tmo;
`else
  assign w_tmo     = 1'b0;
  assign m_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (s_valid) w_next = CLEAR;
      CLEAR:   w_next = FEED;
      FEED:    if (w_hs && s_last) w_next = DRAIN;
      DRAIN:   if (acc_done || w_tmo) w_next = HOLD;
      HOLD:    if (m_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign s_ready = (r_state == FEED);
  assign acc_clr = (r_state == CLEAR);
  assign m_valid = (r_state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_start <= 1'b0;
      r_acc_in1   <= '0;
      r_cnt       <= '0;
      r_nar       <= 1'b0;
      r_m_result  <= '0;
      r_m_inf     <= 1'b0;
      r_m_zero    <= 1'b0;
    end else begin
      r_acc_start <= w_hs;
      if (w_hs) begin
        r_acc_in1 <= s_data;
        if (r_cnt != '1)   r_cnt <= r_cnt + 1'b1;
        if (s_data == NAR) r_nar <= 1'b1;
      end
      if (r_state == DRAIN) begin
        if (acc_done) begin
          r_m_result <= acc_result;
          r_m_zero   <= acc_zero;
          r_m_inf    <= acc_inf | r_nar;
        end else if (w_tmo) begin
          r_m_result <= NAR;
          r_m_zero   <= 1'b0;
          r_m_inf    <= 1'b1;
        end
      end
      if (w_accept) begin
        r_cnt <= '0;
        r_nar <= 1'b0;
      end
    end
  end

  assign acc_start = r_acc_start;
  assign acc_in1   = r_acc_in1;
  assign m_result  = r_m_result;
  assign m_inf     = r_m_inf;
  assign m_zero    = r_m_zero;
  assign m_count   = r_cnt;

endmodule

// File: tb/tb_posit_accum_feeder.sv
// Directed bench for posit_accum_feeder; the accumulator's done/result are driven by hand per batch.
module tb_posit_accum_feeder;
  localparam int N = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid, s_ready, s_last;
  logic [N-1:0]     s_data;
  logic             acc_clr, acc_start;
  logic [N-1:0]     acc_in1, acc_result;
  logic             acc_inf, acc_zero, acc_done;
  logic             m_valid, m_ready;
  logic [N-1:0]     m_result;
  logic             m_inf, m_zero, m_timeout;
  logic [CNT_W-1:0] m_count;

  int checks = 0;
  int errors = 0;

  int          mon_clr = 0;
  int          mon_start = 0;
  logic [31:0] pat = '0;

  posit_accum_feeder #(.N(N), .ES(3), .CNT_W(CNT_W), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .acc_clr(acc_clr), .acc_start(acc_start), .acc_in1(acc_in1),
    .acc_result(acc_result), .acc_inf(acc_inf), .acc_zero(acc_zero), .acc_done(acc_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
    .m_inf(m_inf), .m_zero(m_zero), .m_count(m_count), .m_timeout(m_timeout)
  );

  always #5 clk = ~clk;

  // Per-cycle record of accumulator-side strobes, sampled mid high phase.
  always @(posedge clk) begin
    #3;
    if (acc_clr === 1'b1)   mon_clr <= mon_clr + 1;
    if (acc_start === 1'b1) mon_start <= mon_start + 1;
    pat <= {pat[30:0], acc_start === 1'b1};
  end

  task automatic send(input logic [N-1:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (s_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL send_wait: s_ready=%b required 1 within 20 cycles", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic done_after(input int dly, input logic [N-1:0] res, input logic inf, input logic zero);
    repeat (dly) @(negedge clk);
    acc_result = res; acc_inf = inf; acc_zero = zero; acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
  endtask

  task automatic accept();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 0; s_data = '0; s_last = 0;
    acc_result = '0; acc_inf = 0; acc_zero = 0; acc_done = 0; m_ready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, acc_clr, acc_start, acc_in1, m_valid, m_result, m_inf, m_zero, m_count, m_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: s_ready=%b acc_clr=%b acc_start=%b acc_in1=%h m_valid=%b m_result=%h m_count=%0d required all 0",
               s_ready, acc_clr, acc_start, acc_in1, m_valid, m_result, m_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || acc_clr !== 1'b0) begin
      errors++; $display("FAIL idle_quiet: s_ready=%b acc_clr=%b required 0 0", s_ready, acc_clr);
    end
  endtask

  task automatic test_four_terms();
    int c0 = mon_clr;
    int s0 = mon_start;
    for (int i = 0; i < 4; i++) send(32'h4000_0000, i == 3);
    checks++;
    if (pat[4:0] !== 5'b01111 || mon_start - s0 != 4) begin
      errors++; $display("FAIL four_start_run: pattern=%b count=%0d required 01111 4", pat[4:0], mon_start - s0);
    end
    done_after(5, 32'h4800_0000, 1'b0, 1'b0);
    checks++;
    if (mon_clr - c0 != 1) begin
      errors++; $display("FAIL four_clr: acc_clr cycles=%0d required 1", mon_clr - c0);
    end
    checks++;
    if (m_valid !== 1'b1 || m_result !== 32'h4800_0000 || m_count !== 16'd4 || m_inf !== 1'b0 || m_timeout !== 1'b0) begin
      errors++; $display("FAIL four_result: valid=%b result=%h count=%0d inf=%b tmo=%b required 1 48000000 4 0 0",
                         m_valid, m_result, m_count, m_inf, m_timeout);
    end
    accept();
    checks++;
    if (m_valid !== 1'b0 || m_count !== 16'd0) begin
      errors++; $display("FAIL four_accept: valid=%b count=%0d required 0 0", m_valid, m_count);
    end
  endtask

  task automatic test_nar_hold();
    send(32'h4000_0000, 1'b0);
    send(32'h8000_0000, 1'b0);
    send(32'h4000_0000, 1'b1);
    done_after(2, 32'h4000_0000, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_inf !== 1'b1 || m_result !== 32'h4000_0000 || m_count !== 16'd3) begin
      errors++; $display("FAIL nar_result: valid=%b inf=%b result=%h count=%0d required 1 1 40000000 3",
                         m_valid, m_inf, m_result, m_count);
    end
    s_valid = 1'b1; s_data = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_result !== 32'h4000_0000 || m_count !== 16'd3 || s_ready !== 1'b0) begin
        errors++; $display("FAIL hold_stable[%0d]: valid=%b result=%h count=%0d s_ready=%b required 1 40000000 3 0",
                           i, m_valid, m_result, m_count, s_ready);
      end
    end
    s_valid = 1'b0;
    accept();
    checks++;
    if (m_valid !== 1'b0 || m_inf !== 1'b1) begin
      errors++; $display("FAIL hold_release: valid=%b required 0", m_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_gaps();
    send(32'h4000_0000, 1'b0);
    acc_done = 1'b1;
    @(negedge clk);
    acc_done = 1'b0;
    send(32'h3000_0000, 1'b0);
    @(negedge clk);
    send(32'h5000_0000, 1'b1);
    checks++;
    if (pat[5:0] !== 6'b010101 || acc_in1 !== 32'h5000_0000) begin
      errors++; $display("FAIL gap_pattern: pattern=%b acc_in1=%h required 010101 50000000", pat[5:0], acc_in1);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL feed_done_ignored: m_valid=%b required 0", m_valid);
    end
    done_after(1, 32'h4A00_0000, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_count !== 16'd3 || m_result !== 32'h4A00_0000 || m_inf !== 1'b0) begin
      errors++; $display("FAIL gap_result: valid=%b count=%0d result=%h inf=%b required 1 3 4a000000 0",
                         m_valid, m_count, m_result, m_inf);
    end
    accept();
    @(negedge clk);
    send(32'h0000_0000, 1'b1);
    done_after(0, 32'h0000_0000, 1'b0, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_count !== 16'd1 || m_zero !== 1'b1) begin
      errors++; $display("FAIL single_term: valid=%b count=%0d zero=%b required 1 1 1", m_valid, m_count, m_zero);
    end
    accept();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int c0 = mon_clr;
    send(32'h4000_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    checks++;
    if (m_count !== 16'd2 || acc_start !== 1'b1) begin
      errors++; $display("FAIL mid_count: count=%0d acc_start=%b required 2 1", m_count, acc_start);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ready, acc_clr, acc_start, acc_in1, m_valid, m_result, m_inf, m_zero, m_count, m_timeout} !== '0) begin
      errors++; $display("FAIL mid_reset: s_ready=%b acc_start=%b acc_in1=%h m_valid=%b m_count=%0d required all 0",
                         s_ready, acc_start, acc_in1, m_valid, m_count);
    end
    rst = 1'b0;
    @(negedge clk);
    send(32'h3800_0000, 1'b1);
    done_after(1, 32'h3800_0000, 1'b0, 1'b0);
    checks++;
    if (mon_clr - c0 != 2 || m_count !== 16'd1 || m_result !== 32'h3800_0000) begin
      errors++; $display("FAIL after_reset: clr=%0d count=%0d result=%h required 2 1 38000000",
                         mon_clr - c0, m_count, m_result);
    end
    accept();
    @(negedge clk);
  endtask

`ifdef POSIT_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    send(32'h4000_0000, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) begin
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL tmo_early: m_valid=%b required 0", m_valid); end
      end
    end
    checks++;
    if (m_valid !== 1'b1 || m_timeout !== 1'b1 || m_inf !== 1'b1 || m_result !== 32'h8000_0000) begin
      errors++; $display("FAIL tmo_result: valid=%b tmo=%b inf=%b result=%h required 1 1 1 80000000",
                         m_valid, m_timeout, m_inf, m_result);
    end
    accept();
    checks++;
    if (m_timeout !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL tmo_clear: tmo=%b valid=%b required 0 0", m_timeout, m_valid);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_four_terms();
    test_nar_hold();
    test_gaps();
    test_reset_mid();
`ifdef POSIT_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
